ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction-fetch stage directly upstream of the pipeline register walls. It owns the PC and issues word-addressed requests to instruction memory over a req/ready, valid handshake. Returned words are buffered in a small in-order prefetch queue. The queue head drives the REG1 instruction/PC inputs, freezes on do_hazard and is discarded on redirect (branch/jump/flush).

Parameters:
PC_WIDTH, 10, width of word-address PC (matches current_pc width)
INST_WIDTH, 32, instruction width
QDEPTH, 2, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
im_req  out  1  fetch request valid
im_addr  out  PC_WIDTH  word address of request (= fetch_pc)
im_ready  in  1  memory accepts request this cycle (handshake = im_req & im_ready)
im_valid  in  1  response data valid; responses return in request order, >=1 cycle after acceptance
im_data  in  INST_WIDTH  response instruction
redirect  in  1  discard all fetched/in-flight work, restart at redirect_pc
redirect_pc  in  PC_WIDTH  new fetch address
do_hazard  in  1  stall: hold queue head, no pop
oIF_instruction  out  INST_WIDTH  instruction to REG1 wall (iREG1_instruction)
oIF_current_pc  out  PC_WIDTH  PC of that instruction (iREG1_current_pc)
oIF_valid  out  1  queue head valid

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0; im_req=0; oIF_valid=0; oIF_instruction=0; oIF_current_pc=0. im_req stays 0 in the first cycle after reset deassertion (one-cycle settle).
- Credit rule: im_req=1 iff (occupancy + outstanding) < QDEPTH and not in settle cycle. Queue therefore never overflows; response never lost.
- Accept (im_req&im_ready): outstanding+1; fetch_pc+1, wraps 2^PC_WIDTH-1 -> 0. Each accepted address pushed to a pc tag FIFO (depth QDEPTH) paired with its response.
- Response (im_valid): if drop>0, drop-1, data discarded, tag popped; else push {tag_pc, im_data} into queue. outstanding-1 either way.
- Output: oIF_valid = !empty; oIF_instruction/oIF_current_pc = head when non-empty, else 0 (NOP, same value a REG1 flush inserts). Combinational from queue head registers.
- Pop: at posedge when !empty && !do_hazard && !redirect. Push and pop in the same cycle both occur; occupancy unchanged.
- do_hazard: head and all state frozen except fetch side (requests and responses continue, bounded by credit).
- redirect (highest priority, overrides do_hazard and same-cycle pop/push): queue cleared; fetch_pc=redirect_pc; drop = outstanding after this cycle's events (counting a same-cycle accept, excluding a same-cycle response); any same-cycle im_valid data discarded. A request accepted in the redirect cycle carries the old address and is dropped. New requests from redirect_pc start the next cycle.
- Back-to-back redirects: drop accumulates correctly; a second redirect before the drain finishes takes the newest redirect_pc.
- Outstanding/drop counters are clog2(QDEPTH)+1 bits. Assertion: drop<=outstanding; im_valid never asserted with outstanding=0.
- Reset mid-operation: all counters cleared immediately. Memory must also be reset; responses arriving after reset with outstanding=0 are an assertion error.

Decomposition:
- Shared package: PC_WIDTH, INST_WIDTH, NOP_INST (32'b0), and a fetch_entry typedef {pc, inst}.
- One sub-module: ifetch_queue, a generic synchronous FIFO (push, pop, clear, full, empty, count), instanced twice: the instruction queue and the pc tag FIFO.

Test Plan:
- Reset then zero-wait memory (im_ready=1, 1-cycle latency): im_addr 0,1,2,…; oIF_current_pc 0,1,2 on consecutive cycles from cycle 3 onward; oIF_instruction matches mem[pc].
- do_hazard held 4 cycles with head pc=5: output stays pc=5; im_req drops once occupancy+outstanding=2; after release pc 6,7 follow with no gaps or duplicates.
- redirect to 0x100 while 2 requests are in flight (3-cycle latency): both responses discarded; next oIF_valid shows pc=0x100; no stale pc 3/4 visible.
- redirect and do_hazard in the same cycle: redirect wins, queue empty next cycle, oIF_instruction=0, oIF_valid=0.
- fetch_pc=0x3FF: next request address 0x000, oIF_current_pc sequence 0x3FE,0x3FF,0x000.
- Async reset asserted between posedges with a full queue: outputs go to 0 immediately; after release fetching restarts at RESET_PC with im_req low for exactly one cycle.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_unit_pkg;

  localparam int PC_WIDTH   = 10;
  localparam int INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    FS_SETTLE,
    FS_RUN
  } fetch_state_t;

endpackage

// File: rtl/ifetch_queue.sv
// Generic synchronous FIFO with clear; DEPTH must be a power of two.
module ifetch_queue #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; readers qualify the head with empty.
  always_ff @(posedge clock) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited memory requests and
// presents an in-order prefetch queue head to the REG1 wall.
module ifetch_unit #(
  parameter int                  PC_WIDTH   = 10,
  parameter int                  INST_WIDTH = 32,
  parameter int                  QDEPTH     = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  im_req,
  output logic [PC_WIDTH-1:0]   im_addr,
  input  logic                  im_ready,
  input  logic                  im_valid,
  input  logic [INST_WIDTH-1:0] im_data,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  do_hazard,
  output logic [INST_WIDTH-1:0] oIF_instruction,
  output logic [PC_WIDTH-1:0]   oIF_current_pc,
  output logic                  oIF_valid
);

  import ifetch_unit_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = PC_WIDTH + INST_WIDTH;

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       outstanding_next;
  logic [CW-1:0]       drop;
  logic [CW:0]         credit_used;

  logic                accept;
  logic                q_push;
  logic                q_pop;
  logic [EW-1:0]       q_head;
  logic                q_full;
  logic                q_empty;
  logic [CW-1:0]       q_count;

  logic [PC_WIDTH-1:0] tag_head;
  logic                tag_full;
  logic                tag_empty;
  logic [CW-1:0]       tag_count;

  // Credit counts queued entries plus in-flight requests, so every
  // response is guaranteed a queue slot when it lands.
  always_comb begin
    credit_used      = {1'b0, q_count} + {1'b0, outstanding};
    im_req           = (state == FS_RUN) && (credit_used < (CW+1)'(QDEPTH));
    im_addr          = fetch_pc;
    accept           = im_req && im_ready;
    q_push           = im_valid && !redirect && (drop == '0);
    q_pop            = !q_empty && !do_hazard && !redirect;
    outstanding_next = outstanding + CW'(accept) - CW'(im_valid);
  end

  always_comb begin
    oIF_valid       = !q_empty;
    oIF_current_pc  = q_empty ? '0 : q_head[EW-1 -: PC_WIDTH];
    oIF_instruction = q_empty ? INST_WIDTH'(NOP_INST) : q_head[INST_WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FS_SETTLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= FS_RUN;
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= redirect_pc;
        drop     <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_WIDTH'(1);
        if (im_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  ifetch_queue #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_inst_q (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (q_push),
    .pop       (q_pop),
    .push_data ({tag_head, im_data}),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  ifetch_queue #(
    .WIDTH (PC_WIDTH),
    .DEPTH (QDEPTH)
  ) u_tag_q (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .push      (accept),
    .pop       (im_valid),
    .push_data (fetch_pc),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (drop <= outstanding);
      assert (!(im_valid && (outstanding == '0)));
      assert (!(im_valid && tag_empty));
      assert (!(q_push && q_full && !q_pop));
      assert (!(accept && tag_full));
      assert (tag_count == outstanding);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a latency-programmable memory model
// and a scoreboard of expected {pc, inst} pairs checked on every pop.
module tb_ifetch_unit;

  import ifetch_unit_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  im_req;
  logic [PC_WIDTH-1:0]   im_addr;
  logic                  im_ready;
  logic                  im_valid = 1'b0;
  logic [INST_WIDTH-1:0] im_data  = '0;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  do_hazard;
  logic [INST_WIDTH-1:0] oIF_instruction;
  logic [PC_WIDTH-1:0]   oIF_current_pc;
  logic                  oIF_valid;

  always #5 clock = ~clock;

  ifetch_unit #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .QDEPTH     (2),
    .RESET_PC   (10'h000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .im_req          (im_req),
    .im_addr         (im_addr),
    .im_ready        (im_ready),
    .im_valid        (im_valid),
    .im_data         (im_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .do_hazard       (do_hazard),
    .oIF_instruction (oIF_instruction),
    .oIF_current_pc  (oIF_current_pc),
    .oIF_valid       (oIF_valid)
  );

  function automatic logic [INST_WIDTH-1:0] inst_of(input logic [PC_WIDTH-1:0] pc);
    return {6'h2A, pc, 6'h15, pc};
  endfunction

  // Memory model: in-order responses, 'lat' cycles after acceptance.
  typedef struct {
    logic [PC_WIDTH-1:0] addr;
    int                  due;
  } pend_t;

  pend_t               pend[$];
  int                  cyc = 0;
  int                  lat = 1;
  logic                hs_s = 1'b0;
  logic [PC_WIDTH-1:0] addr_s = '0;

  always @(negedge clock) begin
    hs_s   = im_req && im_ready && !reset;
    addr_s = im_addr;
  end

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      if (im_valid && pend.size() > 0) void'(pend.pop_front());
      if (hs_s) pend.push_back('{addr_s, cyc + lat - 1});
    end else begin
      pend.delete();
    end
    #1;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      im_valid = 1'b1;
      im_data  = inst_of(pend[0].addr);
    end else begin
      im_valid = 1'b0;
      im_data  = '0;
    end
  end

  fetch_entry_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int pops     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_seq(input logic [PC_WIDTH-1:0] start, input int n);
    logic [PC_WIDTH-1:0] pc;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc, inst: inst_of(pc)});
      pc = pc + 10'd1;
    end
  endtask

  // Drive one cycle of control inputs; a head that will pop at the coming
  // edge is checked against the scoreboard first.
  task automatic step(input logic hz, input logic rd, input logic [PC_WIDTH-1:0] rpc);
    fetch_entry_t e;
    do_hazard   = hz;
    redirect    = rd;
    redirect_pc = rpc;
    if (oIF_valid && !hz && !rd) begin
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pop_pc", 64'(oIF_current_pc), 64'(e.pc));
        check("pop_inst", 64'(oIF_instruction), 64'(e.inst));
      end
      pops++;
    end
    if (rd) expect_seq(rpc, 16);
    @(posedge clock);
    #1;
  endtask

  task automatic run_pops(input int n, input int budget);
    int target;
    target = pops + n;
    for (int i = 0; i < budget && pops < target; i++) step(1'b0, 1'b0, '0);
    check("pops_within_budget", 64'(pops >= target), 64'(1));
  endtask

  task automatic wait_valid_held(input int budget);
    for (int i = 0; i < budget && !oIF_valid; i++) step(1'b1, 1'b0, '0);
    check("valid_within_budget", 64'(oIF_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    im_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    do_hazard   = 1'b0;
    lat         = 1;

    // Reset and one-cycle settle
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 64'(oIF_valid), 64'(0));
    check("rst_inst", 64'(oIF_instruction), 64'(0));
    check("rst_pc", 64'(oIF_current_pc), 64'(0));
    check("rst_req", 64'(im_req), 64'(0));
    reset = 1'b0;
    check("settle_req", 64'(im_req), 64'(0));
    check("settle_addr", 64'(im_addr), 64'(0));
    expect_seq(10'h000, 16);
    step(1'b0, 1'b0, '0);
    check("first_req", 64'(im_req), 64'(1));
    check("first_addr", 64'(im_addr), 64'(0));
    step(1'b0, 1'b0, '0);
    check("not_yet_valid", 64'(oIF_valid), 64'(0));
    step(1'b0, 1'b0, '0);
    check("first_valid_latency", 64'(oIF_valid), 64'(1));

    // Stream pcs 0..4, then freeze on pc 5
    run_pops(5, 40);
    wait_valid_held(20);
    for (int i = 0; i < 4; i++) begin
      check("hazard_pc", 64'(oIF_current_pc), 64'(10'h005));
      check("hazard_inst", 64'(oIF_instruction), 64'(inst_of(10'h005)));
      step(1'b1, 1'b0, '0);
    end
    check("hazard_credit_req", 64'(im_req), 64'(0));
    run_pops(3, 40);

    // Redirect with two requests in flight at 3-cycle latency
    lat = 3;
    for (int i = 0; i < 40 && pend.size() != 2; i++) step(1'b0, 1'b0, '0);
    check("inflight_two", 64'(pend.size()), 64'(2));
    step(1'b0, 1'b1, 10'h100);
    check("redir_valid", 64'(oIF_valid), 64'(0));
    run_pops(3, 60);

    // Redirect and hazard together; target near the wrap point
    lat = 1;
    wait_valid_held(30);
    step(1'b1, 1'b1, 10'h3FE);
    check("redir_hz_valid", 64'(oIF_valid), 64'(0));
    check("redir_hz_inst", 64'(oIF_instruction), 64'(0));
    check("redir_hz_pc", 64'(oIF_current_pc), 64'(0));
    check("redir_hz_addr", 64'(im_addr), 64'(10'h3FE));
    run_pops(4, 40);

    // Fill the queue, then assert reset between edges
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    check("full_valid", 64'(oIF_valid), 64'(1));
    check("full_req", 64'(im_req), 64'(0));
    #2;
    reset    = 1'b1;
    im_valid = 1'b0;
    pend.delete();
    #1;
    check("async_valid", 64'(oIF_valid), 64'(0));
    check("async_inst", 64'(oIF_instruction), 64'(0));
    check("async_pc", 64'(oIF_current_pc), 64'(0));
    check("async_req", 64'(im_req), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b0;
    do_hazard = 1'b0;
    check("resettle_req", 64'(im_req), 64'(0));
    check("resettle_addr", 64'(im_addr), 64'(0));
    expect_seq(10'h000, 16);
    step(1'b0, 1'b0, '0);
    check("restart_req", 64'(im_req), 64'(1));
    check("restart_addr", 64'(im_addr), 64'(0));
    run_pops(4, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
